// File: rtl/cgra_config_loader.sv
// -----------------------------------------------------------------------------
// cgra_config_loader
//   Write-side master for the per-PE configuration RAMs. Parses a 32-bit
//   valid/ready word stream made of a header followed by count pairs of
//   payload words (LO then HI). Each pair becomes one 64-bit frame that is
//   written to the shared address/data bus with a one-hot (or broadcast) enable.
//
//   Header word: [31:24] sync 8'hC5, [23:19] count, [18] bcast,
//                [17:8] ignored, [7:4] start_slot, [3:0] pe_id.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   in_data      stream word
//   in_valid     stream word valid
//   in_ready     loader accepts word (always 1 once out of reset)
//   cfg_wr_addr  slot address, shared by all PEs
//   cfg_wr_data  config frame, shared by all PEs
//   cfg_wr_en    per-PE write enable (one-hot, or all-ones on broadcast)
//   busy         packet in progress
//   done         1-cycle pulse with the final write of a packet
//   err          1-cycle pulse after a rejected header
//   err_sticky   set by a rejected header, cleared by err_clr
//   err_clr      clear err_sticky (a simultaneous rejection keeps it set)
// -----------------------------------------------------------------------------
module cgra_config_loader #(
    parameter int unsigned NUM_PE     = 16,
    parameter int unsigned PE_ID_W    = $clog2(NUM_PE),
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH/2-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ADDR_WIDTH-1:0]   cfg_wr_addr,
    output logic [DATA_WIDTH-1:0]   cfg_wr_data,
    output logic [NUM_PE-1:0]       cfg_wr_en,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    err_sticky,
    input  logic                    err_clr
);

    localparam int unsigned WORD_W = DATA_WIDTH / 2;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    localparam logic [7:0]            SYNC_BYTE = 8'hC5;
    localparam logic [CNT_W-1:0]      MAX_COUNT = CNT_W'(DEPTH);
    localparam logic [PE_ID_W:0]      PE_LIMIT  = (PE_ID_W + 1)'(NUM_PE);
    localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [NUM_PE-1:0]     PE_ONE    = NUM_PE'(1);

    logic [1:0]            state_q, state_d;
    logic [PE_ID_W-1:0]    pe_id_q, pe_id_d;
    logic                  bcast_q, bcast_d;
    logic [ADDR_WIDTH-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [WORD_W-1:0]     lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_PE-1:0]     wr_en_q, wr_en_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  sticky_q, sticky_d;
    logic                  ready_q;

    logic                  xfer;
    logic [7:0]            hdr_sync;
    logic [CNT_W-1:0]      hdr_count;
    logic                  hdr_bcast;
    logic [ADDR_WIDTH-1:0] hdr_slot;
    logic [PE_ID_W-1:0]    hdr_pe;
    logic                  hdr_legal;

    assign xfer      = in_valid & ready_q;
    assign hdr_sync  = in_data[31:24];
    assign hdr_count = in_data[23:19];
    assign hdr_bcast = in_data[18];
    assign hdr_slot  = in_data[4 +: ADDR_WIDTH];
    assign hdr_pe    = in_data[0 +: PE_ID_W];

    // An out-of-range pe_id is tolerated only when the packet is broadcast.
    assign hdr_legal = (hdr_sync == SYNC_BYTE) && (hdr_count != '0) &&
                       (hdr_count <= MAX_COUNT) &&
                       (hdr_bcast || ({1'b0, hdr_pe} < PE_LIMIT));

    always_comb begin
        state_d     = state_q;
        pe_id_d     = pe_id_q;
        bcast_d     = bcast_q;
        slot_d      = slot_q;
        remaining_d = remaining_q;
        lo_d        = lo_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_en_d     = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sticky_d    = err_clr ? 1'b0 : sticky_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (hdr_legal) begin
                        pe_id_d     = hdr_pe;
                        bcast_d     = hdr_bcast;
                        slot_d      = hdr_slot;
                        remaining_d = hdr_count;
                        state_d     = ST_LO;
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                end
            end
            ST_LO: begin
                if (xfer) begin
                    lo_d    = in_data;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    data_d      = {in_data, lo_q};
                    addr_d      = slot_q;
                    wr_en_d     = bcast_q ? '1 : (PE_ONE << pe_id_q);
                    slot_d      = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LO;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pe_id_q     <= '0;
            bcast_q     <= 1'b0;
            slot_q      <= '0;
            remaining_q <= '0;
            lo_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pe_id_q     <= pe_id_d;
            bcast_q     <= bcast_d;
            slot_q      <= slot_d;
            remaining_q <= remaining_d;
            lo_q        <= lo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
            ready_q     <= 1'b1;
        end
    end

    assign in_ready    = ready_q;
    assign cfg_wr_addr = addr_q;
    assign cfg_wr_data = data_q;
    assign cfg_wr_en   = wr_en_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign err_sticky  = sticky_q;

endmodule
